fp_i2f_seq: RTL and testbench
=============================

Name: fp_i2f_seq

Overview:
Sequential integer-to-single-precision converter (fcvt.s.w / fcvt.s.wu) for the FPU datapath. It produces IEEE-754 words in the same packed {sign, exp[7:0], frac[22:0]} format that the adder's unpack stage consumes. It uses the FPU r_mode encoding, and valid/ready handshakes on both sides. Normalization is iterative, one bit per cycle, unless the fast-normalize option is compiled in.

Parameters:
BIAS, 127, exponent bias; the exponent load value is BIAS+31 (158).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
int_in  in  32  integer operand
is_signed  in  1  1 = int_in is two's complement, 0 = unsigned
r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
fp_out  out  32  packed single-precision result
inexact  out  1  guard|sticky was nonzero
mode_err  out  1  r_mode was 101..111

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, fp_out=0, inexact=0, mode_err=0.
- rst while in any state aborts the transaction. No result is emitted.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE
  - in_ready=1. Accept on in_valid&&in_ready.
  - Latch sign = is_signed & int_in[31].
  - mag = sign ? (~int_in+1) : int_in, 32-bit. 0x80000000 signed gives mag 0x80000000, read as unsigned.
  - exp = 158. Latch r_mode.
  - Illegal r_mode: set mode_err, then round as RNE.
  - mag==0: result 0x00000000, sign forced to 0, inexact=0, next state DONE.
  - Otherwise next state NORM.
- NORM
  - If mag[31]=1: go to ROUND.
  - Else: mag<=mag<<1, exp<=exp-1, stay in NORM.
  - Occupies lz+1 cycles, where lz is the leading-zero count of mag.
- ROUND
  - frac=mag[30:8], G=mag[7], S=|mag[6:0].
  - Round-up condition per mode:
    - RNE: G&(S|frac[0])
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: !sign&(G|S)
    - RMM: G
  - Increment frac. On carry out of frac[22] (frac was all ones): frac=0, exp=exp+1.
  - Max exp is 159, so no overflow or subnormal is possible.
  - inexact=G|S. Register fp_out={sign,exp,frac}. Next state DONE.
- DONE
  - out_valid=1. fp_out, inexact and mode_err are held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE and drop out_valid.
  - in_ready=0 in every state except IDLE. The block has no bypass, one transaction is in flight at a time, and a new accept is possible the cycle after the handshake.
- Latency, accept edge to out_valid high:
  - Nonzero input: lz+3 cycles.
  - Zero input: 1 cycle.
- out_ready held high while not in DONE has no effect.

Optional Feature:
FP_I2F_FAST_NORM_EN
- Defined: NORM uses a combinational leading-zero count and shifts mag by lz in a single cycle, with exp=158-lz. NORM lasts exactly 1 cycle, so nonzero latency is fixed at 3.
- Undefined: the iterative one-bit-per-cycle shifter described above.
- Results and flags are identical in both builds. Only the timing differs.

Test Plan:
- int_in=1, signed, RNE -> fp_out=0x3F800000, inexact=0. out_valid 34 cycles after accept (3 with FP_I2F_FAST_NORM_EN).
- int_in=0xFFFFFFFF, signed -> 0xBF800000. Same input unsigned, RNE -> 0x4F800000, inexact=1 (carry increments exp). Unsigned RTZ -> 0x4F7FFFFF.
- int_in=0x80000000: signed -> 0xCF000000. Unsigned -> 0x4F000000, inexact=0.
- int_in=0x01000001, unsigned (tie case):
  - RNE -> 0x4B800000
  - RUP -> 0x4B800001
  - RMM -> 0x4B800001
  - RTZ -> 0x4B800000
  - inexact=1 in all four modes.
- int_in=0xFEFFFFFF (-16777217), signed:
  - RDN -> 0xCB800001
  - RUP -> 0xCB800000
  - r_mode=101 -> 0xCB800000 with mode_err=1.
- Handshake and reset:
  - out_ready low for 5 cycles in DONE -> fp_out stable, in_ready=0 throughout.
  - Zero input -> 0x00000000 one cycle after accept.
  - rst asserted mid-NORM -> next cycle IDLE, in_ready=1, out_valid=0, and no stale result afterwards.

Source files
------------

// File: rtl/fp_i2f_seq.sv
// fp_i2f_seq -- sequential integer to single-precision converter
// (fcvt.s.w / fcvt.s.wu) for the FPU datapath.
//
// The result is a packed IEEE-754 word {sign, exp[7:0], frac[22:0]}, the
// same layout the adder's unpack stage consumes. Both sides use valid/ready
// handshakes and only one conversion is in flight at a time.
//
// Build option:
//   FP_I2F_FAST_NORM_EN  defined   -> normalize in one cycle using a
//                                     combinational leading-zero count
//                        undefined -> normalize one bit per cycle
//   Results and flags are the same in both builds; only latency differs.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, aborts any transaction
//   in_valid   request valid
//   in_ready   block can accept a request (high only in IDLE)
//   int_in     32-bit integer operand
//   is_signed  1 = int_in is two's complement, 0 = unsigned
//   r_mode     000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//   out_valid  result valid
//   out_ready  consumer accepts result
//   fp_out     packed single-precision result
//   inexact    guard|sticky was nonzero
//   mode_err   r_mode was 101..111; the conversion rounds as RNE
//
// State  | meaning
// IDLE   | waiting for a request, in_ready high
// NORM   | shifting mag left until bit 31 is set
// ROUND  | apply rounding, build the packed result
// DONE   | result presented, waiting for out_ready

module fp_i2f_seq #(
  parameter int unsigned BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_signed,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_out,
  output logic        inexact,
  output logic        mode_err
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  // Exponent of a value whose leading one sits in bit 31.
  localparam logic [7:0] EXP_LOAD = 8'(BIAS + 31);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [2:0]  rmode_q, rmode_d;
  logic        mode_err_q, mode_err_d;
  logic [31:0] fp_out_q, fp_out_d;
  logic        inexact_q, inexact_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic        sign_in;
  logic [31:0] mag_in;
  logic [22:0] frac;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] frac_inc;
  logic [7:0]  exp_rnd;

`ifdef FP_I2F_FAST_NORM_EN
  logic [4:0]  lz;

  // Position of the highest set bit, expressed as a leading-zero count.
  // Only used on a nonzero magnitude.
  function automatic logic [4:0] lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    rmode_d    = rmode_q;
    mode_err_d = mode_err_q;
    fp_out_d   = fp_out_q;
    inexact_d  = inexact_q;

    sign_in    = is_signed & int_in[31];
    mag_in     = sign_in ? (~int_in + 32'd1) : int_in;
    frac       = mag_q[30:8];
    guard_bit  = mag_q[7];
    sticky_bit = |mag_q[6:0];
    round_up   = 1'b0;
    frac_inc   = 24'd0;
    exp_rnd    = exp_q;
`ifdef FP_I2F_FAST_NORM_EN
    lz         = lzc(mag_q);
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = sign_in;
          mag_d      = mag_in;
          exp_d      = EXP_LOAD;
          rmode_d    = r_mode;
          mode_err_d = (r_mode > 3'd4);
          if (mag_in == 32'd0) begin
            // Zero has no leading one to find; emit +0 directly.
            sign_d    = 1'b0;
            fp_out_d  = 32'd0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
`ifdef FP_I2F_FAST_NORM_EN
        mag_d   = mag_q << lz;
        exp_d   = EXP_LOAD - 8'(lz);
        state_d = ROUND;
`else
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
`endif
      end

      ROUND: begin
        unique case (rmode_q)
          3'd1:    round_up = 1'b0;
          3'd2:    round_up = sign_q & (guard_bit | sticky_bit);
          3'd3:    round_up = ~sign_q & (guard_bit | sticky_bit);
          3'd4:    round_up = guard_bit;
          default: round_up = guard_bit & (sticky_bit | frac[0]);
        endcase
        // A carry out of the fraction leaves it all zeros and bumps the
        // exponent; the largest exponent reachable is BIAS+32, so no overflow.
        frac_inc  = {1'b0, frac} + 24'(round_up);
        exp_rnd   = exp_q + 8'(frac_inc[23]);
        fp_out_d  = {sign_q, exp_rnd, frac_inc[22:0]};
        inexact_d = guard_bit | sticky_bit;
        state_d   = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      rmode_q     <= 3'd0;
      mode_err_q  <= 1'b0;
      fp_out_q    <= 32'd0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      rmode_q     <= rmode_d;
      mode_err_q  <= mode_err_d;
      fp_out_q    <= fp_out_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fp_out    = fp_out_q;
  assign inexact   = inexact_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_fp_i2f_seq.sv
// Testbench for fp_i2f_seq: directed vectors with known results, then
// random operands checked against an arithmetic reference model.
// Honors FP_I2F_FAST_NORM_EN for the expected latency.

module tb_fp_i2f_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        is_signed;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;
  logic        inexact;
  logic        mode_err;

  int checks   = 0;
  int failures = 0;

  fp_i2f_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_in    (int_in),
    .is_signed (is_signed),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out),
    .inexact   (inexact),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: find the leading one, split the magnitude into the 24 kept
  // bits and the discarded remainder, and round by comparing the remainder
  // with half an ulp.
  function automatic void model(input logic [31:0] v, input logic sg, input logic [2:0] rm,
                                output logic [31:0] fp, output logic inx, output int lz);
    logic              s;
    longint unsigned   mag, q, rem, half;
    int                p, e, sh;
    logic              up;
    s   = sg & v[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    fp  = 32'd0;
    inx = 1'b0;
    lz  = 0;
    if (mag == 0) return;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lz = 31 - p;
    e  = 127 + p;
    if (p <= 23) begin
      q    = mag << (23 - p);
      rem  = 0;
      half = 0;
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
    end
    up = 1'b0;
    if (rem != 0) begin
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = s;
        3'd3:    up = !s;
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
    end
    q = q + longint'(up);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    fp  = {s, 8'(e), q[22:0]};
    inx = (rem != 0);
  endfunction

  function automatic int exp_latency(input int lz, input logic zero);
    if (zero) return 1;
`ifdef FP_I2F_FAST_NORM_EN
    return 3;
`else
    return lz + 3;
`endif
  endfunction

  // One full transaction: accept, measure latency, check result, optionally
  // stall for 'hold' cycles in DONE, then complete the output handshake.
  task automatic do_conv(input string tag, input logic [31:0] v, input logic sg,
                         input logic [2:0] rm, input logic [31:0] e_fp,
                         input logic e_inx, input int hold);
    logic [31:0] m_fp;
    logic        m_inx;
    int          lz;
    int          n;
    model(v, sg, rm, m_fp, m_inx, lz);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    int_in    = v;
    is_signed = sg;
    r_mode    = rm;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    int_in    = $urandom;
    is_signed = ~sg;
    r_mode    = 3'($urandom_range(0, 7));
    n = 1;
    while (!out_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_latency(lz, (m_fp == 32'd0) && !m_inx && (v == 32'd0 || (sg && v == 32'd0)))));
    check({tag, ".fp_out"}, fp_out, e_fp);
    check({tag, ".inexact"}, 32'(inexact), 32'(e_inx));
    check({tag, ".mode_err"}, 32'(mode_err), 32'(rm > 3'd4));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".stall_fp"}, fp_out, e_fp);
      check({tag, ".stall_inrdy"}, 32'(in_ready), 32'd0);
      check({tag, ".stall_ovld"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".post_ovld"}, 32'(out_valid), 32'd0);
    check({tag, ".post_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] m_fp;
    logic        m_inx;
    int          lz;
    int          seen;
    logic [31:0] v;
    logic        sg;
    logic [2:0]  rm;

    rst       = 1'b1;
    in_valid  = 1'b0;
    int_in    = 32'd0;
    is_signed = 1'b0;
    r_mode    = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.fp_out", fp_out, 32'd0);
    check("rst.inexact", 32'(inexact), 32'd0);
    check("rst.mode_err", 32'(mode_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_conv("one_s_rne",    32'h0000_0001, 1'b1, 3'd0, 32'h3F80_0000, 1'b0, 0);
    do_conv("m1_s_rne",     32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0, 0);
    do_conv("ffff_u_rne",   32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 1'b1, 0);
    do_conv("ffff_u_rtz",   32'hFFFF_FFFF, 1'b0, 3'd1, 32'h4F7F_FFFF, 1'b1, 0);
    do_conv("min_s",        32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 1'b0, 0);
    do_conv("min_u",        32'h8000_0000, 1'b0, 3'd0, 32'h4F00_0000, 1'b0, 0);
    do_conv("tie_rne",      32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, 0);
    do_conv("tie_rup",      32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1, 0);
    do_conv("tie_rmm",      32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1, 0);
    do_conv("tie_rtz",      32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1, 0);
    do_conv("neg_rdn",      32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0001, 1'b1, 0);
    do_conv("neg_rup",      32'hFEFF_FFFF, 1'b1, 3'd3, 32'hCB80_0000, 1'b1, 0);
    do_conv("neg_badmode",  32'hFEFF_FFFF, 1'b1, 3'd5, 32'hCB80_0000, 1'b1, 0);
    do_conv("stall5",       32'h0000_0005, 1'b0, 3'd0, 32'h40A0_0000, 1'b0, 5);
    do_conv("zero",         32'h0000_0000, 1'b1, 3'd2, 32'h0000_0000, 1'b0, 0);

    // Reset while NORM is still shifting.
    in_valid  = 1'b1;
    int_in    = 32'h0000_0001;
    is_signed = 1'b1;
    r_mode    = 3'd0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.fp_out", fp_out, 32'd0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst.no_stale", 32'(seen), 32'd0);
    do_conv("after_rst",    32'h0000_0007, 1'b1, 3'd1, 32'h40E0_0000, 1'b0, 0);

    // Random operands with varied leading-zero counts, all modes.
    for (int k = 0; k < 40; k++) begin
      v  = $urandom >> $urandom_range(0, 31);
      sg = 1'($urandom_range(0, 1));
      rm = 3'($urandom_range(0, 7));
      if (k % 5 == 0 && sg) v = ~v;
      model(v, sg, rm, m_fp, m_inx, lz);
      do_conv($sformatf("rand%0d_%h_%0d_%0d", k, v, sg, rm), v, sg, rm, m_fp, m_inx, k % 7 == 3 ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
